// File: rtl/ex_result_stage_if.sv
// Bundle of handshake, payload, forwarding and retire-count signals for
// the execute result stage. The slave modport is the stage itself; the
// master modport is the upstream/downstream environment driving it.
interface ex_result_stage_if #(
  parameter int WIDTH = 16,
  parameter int REGW  = 3
);
  // squash control
  logic             flush;

  // upstream side
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] btr_res;
  logic             set_flag;
  logic [WIDTH-1:0] imm_res;
  logic             in_wr_en;
  logic [REGW-1:0]  in_wr_reg;

  // downstream side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_wr_en;
  logic [REGW-1:0]  out_wr_reg;

  // forwarding tap and retire statistics
  logic             fwd_valid;
  logic [REGW-1:0]  fwd_reg;
  logic [WIDTH-1:0] fwd_data;
  logic [15:0]      retire_cnt;

  modport slave (
    input  flush,
    input  in_valid, in_sel, alu_res, btr_res, set_flag, imm_res,
    input  in_wr_en, in_wr_reg,
    output in_ready,
    output out_valid, out_result, out_wr_en, out_wr_reg,
    input  out_ready,
    output fwd_valid, fwd_reg, fwd_data,
    output retire_cnt
  );

  modport master (
    output flush,
    output in_valid, in_sel, alu_res, btr_res, set_flag, imm_res,
    output in_wr_en, in_wr_reg,
    input  in_ready,
    input  out_valid, out_result, out_wr_en, out_wr_reg,
    output out_ready,
    input  fwd_valid, fwd_reg, fwd_data,
    input  retire_cnt
  );
endinterface

// File: rtl/ex_result_stage.sv
// Execute result stage: selects the result source, holds it in a two-entry
// skid buffer (head + skid), and exposes the head to MEM and to the
// forwarding network. in_ready depends only on the buffer state so the
// upstream handshake never sees a combinational path from out_ready.
module ex_result_stage #(
  parameter int WIDTH = 16,
  parameter int REGW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  ex_result_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // head entry (what MEM sees) and skid entry (overflow slot)
  logic [WIDTH-1:0] r_head_result;
  logic             r_head_wr_en;
  logic [REGW-1:0]  r_head_wr_reg;
  logic [WIDTH-1:0] r_skid_result;
  logic             r_skid_wr_en;
  logic [REGW-1:0]  r_skid_wr_reg;
  logic [15:0]      r_retire_cnt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_pop;
  logic [WIDTH-1:0] w_in_result;
  logic             w_load_head_in;
  logic             w_load_head_skid;
  logic             w_load_skid;

  // readiness and validity are pure decodes of the state register
  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  // result source select for the incoming entry
  always_comb begin
    w_in_result = bus.alu_res;
    case (bus.in_sel)
      2'b00:   w_in_result = bus.alu_res;
      2'b01:   w_in_result = bus.btr_res;
      2'b10:   w_in_result = {{(WIDTH-1){1'b0}}, bus.set_flag};
      2'b11:   w_in_result = bus.imm_res;
      default: w_in_result = bus.alu_res;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state and slot-load decisions; flush overrides everything and
  // suppresses loads (contents of invalid slots are don't-care)
  always_comb begin
    w_state_next     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_next   = HALF;
            w_load_head_in = 1'b1;
          end
        end
        HALF: begin
          if (w_accept && !w_pop) begin
            w_state_next = FULL;
            w_load_skid  = 1'b1;
          end else if (w_pop && !w_accept) begin
            w_state_next = EMPTY;
          end else if (w_accept && w_pop) begin
            w_state_next   = HALF;
            w_load_head_in = 1'b1;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_state_next     = HALF;
            w_load_head_skid = 1'b1;
          end
        end
        default: begin
          w_state_next = EMPTY;
        end
      endcase
    end
  end

  // head slot: loaded from the input or promoted from the skid slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_result <= '0;
      r_head_wr_en  <= 1'b0;
      r_head_wr_reg <= '0;
    end else if (w_load_head_in) begin
      r_head_result <= w_in_result;
      r_head_wr_en  <= bus.in_wr_en;
      r_head_wr_reg <= bus.in_wr_reg;
    end else if (w_load_head_skid) begin
      r_head_result <= r_skid_result;
      r_head_wr_en  <= r_skid_wr_en;
      r_head_wr_reg <= r_skid_wr_reg;
    end
  end

  // skid slot: only written when the head is occupied and not draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_result <= '0;
      r_skid_wr_en  <= 1'b0;
      r_skid_wr_reg <= '0;
    end else if (w_load_skid) begin
      r_skid_result <= w_in_result;
      r_skid_wr_en  <= bus.in_wr_en;
      r_skid_wr_reg <= bus.in_wr_reg;
    end
  end

  // retire counter: counts every pop, including one coincident with flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_pop) begin
      r_retire_cnt <= r_retire_cnt + 16'd1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = r_head_result;
  assign bus.out_wr_en  = r_head_wr_en;
  assign bus.out_wr_reg = r_head_wr_reg;
  assign bus.fwd_valid  = w_out_valid & r_head_wr_en;
  assign bus.fwd_reg    = r_head_wr_reg;
  assign bus.fwd_data   = r_head_result;
  assign bus.retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage with a scoreboard queue: entries are
// pushed when the bench drives an accepted transfer and compared against
// the head whenever the stage is expected to hold something.
module tb_ex_result_stage;
  localparam int WIDTH = 16;
  localparam int REGW  = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // scoreboard entries: {wr_reg, wr_en, result}
  logic [19:0] sb_q[$];
  logic [15:0] exp_retire;

  ex_result_stage_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();

  ex_result_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference result for the currently driven inputs
  function automatic logic [19:0] ref_entry();
    logic [15:0] res;
    case (bus.in_sel)
      2'b00:   res = bus.alu_res;
      2'b01:   res = bus.btr_res;
      2'b10:   res = {15'd0, bus.set_flag};
      default: res = bus.imm_res;
    endcase
    return {bus.in_wr_reg, bus.in_wr_en, res};
  endfunction

  task automatic drive(input logic v, input logic [1:0] sel, input logic [15:0] alu,
                       input logic [15:0] btr, input logic flag, input logic [15:0] imm,
                       input logic we, input logic [2:0] wr);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.alu_res   = alu;
    bus.btr_res   = btr;
    bus.set_flag  = flag;
    bus.imm_res   = imm;
    bus.in_wr_en  = we;
    bus.in_wr_reg = wr;
  endtask

  // one clock: check outputs against the model (unless quiet), update the
  // model with this cycle's accept/pop/flush, advance to the next negedge
  task automatic cycle(input bit quiet);
    bit          pop;
    bit          acc;
    logic [19:0] e;
    logic [19:0] h;
    if (!quiet) begin
      chk("in_ready", bus.in_ready, (sb_q.size() < 2) ? 1 : 0);
      chk("out_valid", bus.out_valid, (sb_q.size() > 0) ? 1 : 0);
      chk("retire_cnt", bus.retire_cnt, exp_retire);
      if (sb_q.size() > 0) begin
        h = sb_q[0];
        chk("out_result", bus.out_result, h[15:0]);
        chk("out_wr_en", bus.out_wr_en, h[16]);
        chk("out_wr_reg", bus.out_wr_reg, h[19:17]);
        chk("fwd_valid", bus.fwd_valid, h[16]);
        chk("fwd_reg", bus.fwd_reg, h[19:17]);
        chk("fwd_data", bus.fwd_data, h[15:0]);
      end else begin
        chk("fwd_valid_idle", bus.fwd_valid, 0);
      end
    end
    pop = bus.out_ready && (sb_q.size() > 0);
    acc = bus.in_valid && (sb_q.size() < 2);
    e   = ref_entry();
    if (pop) begin
      h = sb_q.pop_front();
      exp_retire = exp_retire + 16'd1;
      if (!quiet) $display("pop    result=%h wr_en=%0d wr_reg=%0d", h[15:0], h[16], h[19:17]);
    end
    if (bus.flush) begin
      sb_q.delete();
      if (!quiet) $display("flush");
    end else if (acc) begin
      sb_q.push_back(e);
      if (!quiet) $display("accept result=%h wr_en=%0d wr_reg=%0d", e[15:0], e[16], e[19:17]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    checks     = 0;
    failures   = 0;
    exp_retire = 16'd0;
    rst        = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);

    // reset state while rst held
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_fwd_valid", bus.fwd_valid, 0);
    chk("rst_retire", bus.retire_cnt, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_wr_en", bus.out_wr_en, 0);
    chk("rst_out_wr_reg", bus.out_wr_reg, 0);
    @(negedge clk);
    rst = 1'b0;

    // bypass through the bit-reverse source
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b01, 16'h0, 16'h8001, 1'b0, 16'h0, 1'b1, 3'd5);
    cycle(0);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    cycle(0);
    cycle(0);

    // set-flag select ignores alu_res
    drive(1'b1, 2'b10, 16'hFFFF, 16'h0, 1'b1, 16'h0, 1'b1, 3'd2);
    cycle(0);
    // ALU and immediate sources back to back (HALF accept & pop)
    drive(1'b1, 2'b00, 16'hA5A5, 16'h0, 1'b0, 16'h0, 1'b0, 3'd3);
    cycle(0);
    drive(1'b1, 2'b11, 16'h0, 16'h0, 1'b0, 16'h1234, 1'b1, 3'd7);
    cycle(0);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    cycle(0);
    cycle(0);

    // backpressure: fill, third push ignored, then drain
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h1111, 16'h0, 1'b0, 16'h0, 1'b1, 3'd1);
    cycle(0);
    drive(1'b1, 2'b00, 16'h2222, 16'h0, 1'b0, 16'h0, 1'b1, 3'd2);
    cycle(0);
    drive(1'b1, 2'b00, 16'h3333, 16'h0, 1'b0, 16'h0, 1'b1, 3'd3);
    cycle(0);
    cycle(0);
    drive(1'b0, 2'b00, 16'h4444, 16'h0, 1'b0, 16'h0, 1'b1, 3'd4);
    bus.out_ready = 1'b1;
    cycle(0);
    cycle(0);
    cycle(0);

    // random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      bus.out_ready = 1'($urandom_range(0, 1));
      cycle(0);
    end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    bus.out_ready = 1'b1;
    cycle(0);
    cycle(0);
    cycle(0);

    // flush while FULL with a same-cycle push: everything discarded
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b11, 16'h0, 16'h0, 1'b0, 16'hAAAA, 1'b1, 3'd1);
    cycle(0);
    drive(1'b1, 2'b11, 16'h0, 16'h0, 1'b0, 16'hBBBB, 1'b1, 3'd2);
    cycle(0);
    drive(1'b1, 2'b11, 16'h0, 16'h0, 1'b0, 16'hCCCC, 1'b1, 3'd3);
    bus.flush = 1'b1;
    cycle(0);
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    cycle(0);

    // flush coincident with a pop still counts the retirement
    drive(1'b1, 2'b00, 16'h5555, 16'h0, 1'b0, 16'h0, 1'b1, 3'd6);
    cycle(0);
    drive(1'b1, 2'b00, 16'h6666, 16'h0, 1'b0, 16'h0, 1'b1, 3'd6);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    cycle(0);
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    cycle(0);

    // asynchronous reset between edges while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h7777, 16'h0, 1'b0, 16'h0, 1'b1, 3'd1);
    cycle(0);
    drive(1'b1, 2'b00, 16'h8888, 16'h0, 1'b0, 16'h0, 1'b1, 3'd2);
    cycle(0);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    chk("full_before_rst", bus.in_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_retire", bus.retire_cnt, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_out_result", bus.out_result, 0);
    #1;
    rst = 1'b0;
    sb_q.delete();
    exp_retire = 16'd0;
    @(negedge clk);

    // first accept after reset behaves as from EMPTY
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b01, 16'h0, 16'h0F0F, 1'b0, 16'h0, 1'b1, 3'd4);
    cycle(0);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    cycle(0);
    cycle(0);

    // counter wrap: stream until 0xFFFF retirements, then one more
    drive(1'b1, 2'b00, 16'h0001, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    guard = 0;
    while (exp_retire != 16'hFFFF && guard < 70000) begin
      cycle(1);
      guard++;
    end
    chk("wrap_reached", (exp_retire == 16'hFFFF) ? 1 : 0, 1);
    chk("retire_ffff", bus.retire_cnt, 16'hFFFF);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 3'd0);
    cycle(0);
    chk("retire_wrap", bus.retire_cnt, 16'h0000);
    cycle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
